// File: rtl/sparse_dense_layer_ctrl.sv
// Sparse fully-connected output layer: bias init, zero-skipping
// saturating MAC over non-zero activations, then argmax readout.
module sparse_dense_layer_ctrl #(
  parameter int N_IN  = 16,
  parameter int IN_W  = 8,
  parameter int N_OUT = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int IDX_W = $clog2(N_IN),
  parameter int CLS_W = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CLS_W-1:0]     out_class,
  output logic [ACC_W-1:0]     out_score,
  output logic                 sat_flag,
  input  logic                 wr_en,
  input  logic                 wr_bias,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [N_OUT*W_W-1:0] wr_data,
  output logic                 busy
);

  localparam int PROD_W = IN_W + W_W + 1;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MAC,
    ARGMAX,
    DONE
  } state_t;

  state_t state;

  logic                    inReady;
  logic                    outValid;
  logic                    busyQ;
  logic                    satFlag;
  logic [CLS_W-1:0]        outClass;
  logic signed [ACC_W-1:0] outScore;

  logic signed [W_W-1:0]   weights [N_IN][N_OUT];
  logic signed [W_W-1:0]   biases  [N_OUT];

  logic [IN_W-1:0]         act  [N_IN];
  logic [N_IN-1:0]         mask;
  logic signed [ACC_W-1:0] acc  [N_OUT];

  logic                    rowOk;
  logic [IDX_W-1:0]        selIdx;
  logic signed [PROD_W-1:0] actExt;
  logic signed [PROD_W-1:0] wExt   [N_OUT];
  logic signed [PROD_W-1:0] prod   [N_OUT];
  logic signed [SUM_W-1:0]  sum    [N_OUT];
  logic signed [ACC_W-1:0]  macAcc [N_OUT];
  logic [N_OUT-1:0]         clipVec;
  logic signed [SUM_W-1:0]  accMax;
  logic signed [SUM_W-1:0]  accMin;

  logic [CLS_W-1:0]        bestIdx;
  logic signed [ACC_W-1:0] bestVal;

  assign in_ready  = inReady;
  assign out_valid = outValid;
  assign busy      = busyQ;
  assign sat_flag  = satFlag;
  assign out_class = outClass;
  assign out_score = outScore;

  assign accMax = SUM_W'({(ACC_W-1){1'b1}});
  assign accMin = ~accMax;
  assign rowOk  = int'(wr_addr) < N_IN;

  // Writes land whenever no job is reading the arrays.
  always_ff @(posedge clk) begin
    if (!busyQ && wr_en && rowOk) begin
      for (int j = 0; j < N_OUT; j++) begin
        weights[wr_addr][j] <= wr_data[j*W_W +: W_W];
      end
    end
    if (!busyQ && wr_bias) begin
      for (int j = 0; j < N_OUT; j++) begin
        biases[j] <= wr_data[j*W_W +: W_W];
      end
    end
  end

  // Lowest pending non-zero activation is the next one scheduled.
  always_comb begin
    selIdx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (mask[i]) selIdx = IDX_W'(i);
    end
  end

  always_comb begin
    actExt  = $signed(PROD_W'(act[selIdx]));
    clipVec = '0;
    for (int j = 0; j < N_OUT; j++) begin
      wExt[j]   = PROD_W'(weights[selIdx][j]);
      prod[j]   = actExt * wExt[j];
      sum[j]    = SUM_W'(acc[j]) + SUM_W'(prod[j]);
      macAcc[j] = sum[j][ACC_W-1:0];
      if (sum[j] > accMax) begin
        macAcc[j]  = accMax[ACC_W-1:0];
        clipVec[j] = 1'b1;
      end else if (sum[j] < accMin) begin
        macAcc[j]  = accMin[ACC_W-1:0];
        clipVec[j] = 1'b1;
      end
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    bestIdx = '0;
    bestVal = acc[0];
    for (int j = 1; j < N_OUT; j++) begin
      if (acc[j] > bestVal) begin
        bestIdx = CLS_W'(j);
        bestVal = acc[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busyQ    <= 1'b0;
      satFlag  <= 1'b0;
      outClass <= '0;
      outScore <= '0;
      mask     <= '0;
      for (int k = 0; k < N_IN; k++) begin
        act[k] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        acc[j] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_IN; k++) begin
              act[k] <= in_data[k*IN_W +: IN_W];
            end
            inReady <= 1'b0;
            busyQ   <= 1'b1;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          for (int k = 0; k < N_IN; k++) begin
            mask[k] <= |act[k];
          end
          for (int j = 0; j < N_OUT; j++) begin
            acc[j] <= ACC_W'(biases[j]);
          end
          satFlag <= 1'b0;
          state   <= MAC;
        end
        MAC: begin
          if (mask == '0) begin
            state <= ARGMAX;
          end else begin
            for (int j = 0; j < N_OUT; j++) begin
              acc[j] <= macAcc[j];
            end
            mask[selIdx] <= 1'b0;
            if (|clipVec) satFlag <= 1'b1;
          end
        end
        ARGMAX: begin
          outClass <= bestIdx;
          outScore <= bestVal;
          outValid <= 1'b1;
          busyQ    <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          inReady  <= 1'b1;
          outValid <= 1'b0;
          busyQ    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_dense_layer_ctrl.sv
// Bench for sparse_dense_layer_ctrl: scoreboard of model results
// plus per-scenario latency, handshake and write checks.
module tb_sparse_dense_layer_ctrl;

  localparam int N_IN  = 16;
  localparam int IN_W  = 8;
  localparam int N_OUT = 10;
  localparam int W_W   = 8;
  localparam int ACC_W = 16;
  localparam int IDX_W = $clog2(N_IN);
  localparam int CLS_W = $clog2(N_OUT);
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  typedef logic [N_IN*IN_W-1:0] vec_t;
  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [ACC_W-1:0] score;
    logic             sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  vec_t                 in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CLS_W-1:0]     out_class;
  logic [ACC_W-1:0]     out_score;
  logic                 sat_flag;
  logic                 wr_en = 1'b0;
  logic                 wr_bias = 1'b0;
  logic [IDX_W-1:0]     wr_addr = '0;
  logic [N_OUT*W_W-1:0] wr_data = '0;
  logic                 busy;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t sb[$];
  int   mW[N_IN][N_OUT];
  int   mB[N_OUT];
  logic prevValid = 1'b0;

  sparse_dense_layer_ctrl #(
    .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .W_W(W_W),
    .ACC_W(ACC_W), .IDX_W(IDX_W), .CLS_W(CLS_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score),
    .sat_flag(sat_flag),
    .wr_en(wr_en), .wr_bias(wr_bias), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input vec_t d);
    longint acc[N_OUT];
    longint a;
    int     best;
    exp_t   e;
    e.sat = 1'b0;
    for (int j = 0; j < N_OUT; j++) acc[j] = longint'(mB[j]);
    for (int k = 0; k < N_IN; k++) begin
      a = longint'(d[k*IN_W +: IN_W]);
      if (a != 0) begin
        for (int j = 0; j < N_OUT; j++) begin
          acc[j] += a * longint'(mW[k][j]);
          if (acc[j] > ACC_MAX) begin
            acc[j] = ACC_MAX;
            e.sat = 1'b1;
          end else if (acc[j] < ACC_MIN) begin
            acc[j] = ACC_MIN;
            e.sat = 1'b1;
          end
        end
      end
    end
    best = 0;
    for (int j = 1; j < N_OUT; j++) if (acc[j] > acc[best]) best = j;
    e.cls   = CLS_W'(best);
    e.score = ACC_W'(acc[best]);
    return e;
  endfunction

  // Scoreboard: every rising out_valid consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prevValid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected class=%0d score=%0d required=none",
                 out_class, $signed(out_score));
      end else begin
        e = sb.pop_front();
        if (out_class !== e.cls || out_score !== e.score ||
            sat_flag !== e.sat)
          $display("FAIL sb_result got c=%0d s=%0d sat=%0b required c=%0d s=%0d sat=%0b",
                   out_class, $signed(out_score), sat_flag,
                   e.cls, $signed(e.score), e.sat);
        else passed++;
      end
    end
    prevValid <= out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic write_vec(input bit row, input bit bias, input int addr,
                           input int v[N_OUT], input bit lands);
    wr_en   = row;
    wr_bias = bias;
    wr_addr = IDX_W'(addr);
    for (int j = 0; j < N_OUT; j++) wr_data[j*W_W +: W_W] = W_W'(v[j]);
    if (lands) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (row) mW[addr][j] = v[j];
        if (bias) mB[j] = v[j];
      end
    end
    @(negedge clk);
    wr_en   = 1'b0;
    wr_bias = 1'b0;
  endtask

  task automatic load_identity();
    int v[N_OUT];
    for (int k = 0; k < N_IN; k++) begin
      for (int j = 0; j < N_OUT; j++) v[j] = (j == k % N_OUT) ? 1 : 0;
      write_vec(1'b1, 1'b0, k, v, 1'b1);
    end
    for (int j = 0; j < N_OUT; j++) v[j] = 0;
    write_vec(1'b0, 1'b1, 0, v, 1'b1);
  endtask

  task automatic send(input vec_t d, input bit want, output int accCyc);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    if (want) sb.push_back(model(d));
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) $display("FAIL send_accept in_ready=%0b required=1", in_ready);
    else passed++;
    @(negedge clk);
    accCyc   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int accCyc, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = out_valid ? cyc - accCyc : -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec_t d;
    int   ac;
    bit   seen;
    repeat (2) @(negedge clk);
    total += 6;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b required=1", in_ready);
    else passed++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b required=0", out_valid);
    else passed++;
    if (out_class !== '0) $display("FAIL rst_out_class got=%0d required=0", out_class);
    else passed++;
    if (out_score !== '0) $display("FAIL rst_out_score got=%0d required=0", out_score);
    else passed++;
    if (sat_flag !== 1'b0) $display("FAIL rst_sat_flag got=%0b required=0", sat_flag);
    else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%0b required=0", busy);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    load_identity();
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = 8'd1;
    send(d, 1'b0, ac);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL rst_mid_busy got=%0b required=1", busy);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_abort got v=%0b r=%0b b=%0b required v=0 r=1 b=0",
               out_valid, in_ready, busy);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= out_valid;
    end
    total++;
    if (seen) $display("FAIL rst_no_output got out_valid=1 required=0");
    else passed++;
  endtask

  task automatic test_sparse();
    vec_t d;
    int   ac;
    int   lat;
    d = '0;
    d[2*IN_W +: IN_W] = 8'd5;
    d[7*IN_W +: IN_W] = 8'd9;
    send(d, 1'b1, ac);
    wait_valid(ac, lat);
    total += 4;
    if (lat != 5) $display("FAIL sparse_latency got=%0d required=5", lat);
    else passed++;
    if (out_class !== CLS_W'(7) || out_score !== ACC_W'(9))
      $display("FAIL sparse_result got c=%0d s=%0d required c=7 s=9",
               out_class, out_score);
    else passed++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL sparse_done_flags got r=%0b b=%0b required r=0 b=0",
               in_ready, busy);
    else passed++;
    consume();
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL sparse_release got v=%0b r=%0b required v=0 r=1",
               out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_writes();
    vec_t d;
    int   ac;
    int   lat;
    int   v[N_OUT];
    d = '0;
    d[3*IN_W +: IN_W] = 8'd20;
    send(d, 1'b1, ac);
    wait_valid(ac, lat);
    total++;
    if (out_class !== CLS_W'(3) || out_score !== ACC_W'(20))
      $display("FAIL wr_base got c=%0d s=%0d required c=3 s=20", out_class, out_score);
    else passed++;
    consume();
    send(d, 1'b1, ac);
    total++;
    if (busy !== 1'b1) $display("FAIL wr_busy got=%0b required=1", busy);
    else passed++;
    for (int j = 0; j < N_OUT; j++) v[j] = (j == 0) ? 100 : 50;
    write_vec(1'b1, 1'b1, 3, v, 1'b0);
    wait_valid(ac, lat);
    consume();
    send(d, 1'b1, ac);
    wait_valid(ac, lat);
    total++;
    if (out_class !== CLS_W'(3) || out_score !== ACC_W'(20))
      $display("FAIL wr_dropped got c=%0d s=%0d required c=3 s=20", out_class, out_score);
    else passed++;
    consume();
    for (int j = 0; j < N_OUT; j++) v[j] = (j == 9) ? 2 : 0;
    wr_en   = 1'b1;
    wr_addr = IDX_W'(3);
    for (int j = 0; j < N_OUT; j++) begin
      wr_data[j*W_W +: W_W] = W_W'(v[j]);
      mW[3][j] = v[j];
    end
    send(d, 1'b1, ac);
    wr_en = 1'b0;
    wait_valid(ac, lat);
    total++;
    if (out_class !== CLS_W'(9) || out_score !== ACC_W'(40))
      $display("FAIL wr_accept_edge got c=%0d s=%0d required c=9 s=40",
               out_class, out_score);
    else passed++;
    consume();
  endtask

  task automatic test_zero();
    int ac;
    int lat;
    int v[N_OUT];
    v = '{0, 1, 2, -1, 3, 3, 0, -7, 2, 1};
    write_vec(1'b1, 1'b1, 5, v, 1'b1);
    send('0, 1'b1, ac);
    wait_valid(ac, lat);
    total += 2;
    if (lat != 3) $display("FAIL zero_latency got=%0d required=3", lat);
    else passed++;
    if (out_class !== CLS_W'(4) || out_score !== ACC_W'(3))
      $display("FAIL zero_result got c=%0d s=%0d required c=4 s=3", out_class, out_score);
    else passed++;
    consume();
    for (int j = 0; j < N_OUT; j++) v[j] = 0;
    write_vec(1'b0, 1'b1, 0, v, 1'b1);
    out_ready = 1'b1;
    send('0, 1'b1, ac);
    wait_valid(ac, lat);
    total += 2;
    if (lat != 3 || out_class !== '0 || out_score !== '0)
      $display("FAIL zero_tie got lat=%0d c=%0d s=%0d required lat=3 c=0 s=0",
               lat, out_class, out_score);
    else passed++;
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL zero_early_ready got v=%0b r=%0b required v=0 r=1",
               out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_saturation();
    vec_t d;
    int   ac;
    int   lat;
    int   v[N_OUT];
    for (int j = 0; j < N_OUT; j++) v[j] = -128;
    for (int k = 0; k < N_IN; k++) write_vec(1'b1, 1'b0, k, v, 1'b1);
    for (int j = 0; j < N_OUT; j++) v[j] = 0;
    write_vec(1'b0, 1'b1, 0, v, 1'b1);
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = 8'd255;
    send(d, 1'b1, ac);
    wait_valid(ac, lat);
    total += 3;
    if (lat != 19) $display("FAIL sat_latency got=%0d required=19", lat);
    else passed++;
    if (out_class !== '0 || out_score !== ACC_W'(16'h8000) || sat_flag !== 1'b1)
      $display("FAIL sat_result got c=%0d s=%0d f=%0b required c=0 s=-32768 f=1",
               out_class, $signed(out_score), sat_flag);
    else passed++;
    consume();
    if (sat_flag !== 1'b1) $display("FAIL sat_hold got=%0b required=1", sat_flag);
    else passed++;
  endtask

  task automatic test_backpressure();
    vec_t d;
    vec_t d2;
    int   ac;
    int   lat;
    int   rc;
    bit   ok;
    load_identity();
    d = '0;
    d[0*IN_W +: IN_W]  = 8'd10;
    d[11*IN_W +: IN_W] = 8'd30;
    send(d, 1'b1, ac);
    wait_valid(ac, lat);
    ok = 1'b1;
    repeat (10) begin
      if (out_valid !== 1'b1 || out_class !== CLS_W'(1) ||
          out_score !== ACC_W'(30) || in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok)
      $display("FAIL bp_stable got v=%0b c=%0d s=%0d r=%0b required v=1 c=1 s=30 r=0",
               out_valid, out_class, out_score, in_ready);
    else passed++;
    d2 = '0;
    d2[4*IN_W +: IN_W] = 8'd7;
    sb.push_back(model(d2));
    in_data   = d2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rc = cyc;
    @(negedge clk);
    out_ready = 1'b0;
    total += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
    else passed++;
    @(negedge clk);
    ac = cyc;
    in_valid = 1'b0;
    if (ac != rc + 2 || in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_next_accept got cyc=%0d r=%0b b=%0b required cyc=%0d r=0 b=1",
               ac - rc, in_ready, busy, 2);
    else passed++;
    wait_valid(ac, lat);
    total++;
    if (lat != 4) $display("FAIL bp_latency got=%0d required=4", lat);
    else passed++;
    consume();
  endtask

  task automatic test_back_to_back();
    vec_t d;
    int   ac;
    int   lat;
    int   p;
    int   v[N_OUT];
    for (int k = 0; k < N_IN; k++) begin
      for (int j = 0; j < N_OUT; j++) v[j] = int'($urandom_range(0, 255)) - 128;
      write_vec(1'b1, 1'b0, k, v, 1'b1);
    end
    for (int j = 0; j < N_OUT; j++) v[j] = int'($urandom_range(0, 255)) - 128;
    write_vec(1'b0, 1'b1, 0, v, 1'b1);
    for (int t = 0; t < 8; t++) begin
      p = 0;
      for (int k = 0; k < N_IN; k++) begin
        d[k*IN_W +: IN_W] = ($urandom_range(0, 1) == 1) ?
                            IN_W'($urandom_range(1, 255)) : '0;
        if (d[k*IN_W +: IN_W] != '0) p++;
      end
      send(d, 1'b1, ac);
      wait_valid(ac, lat);
      total++;
      if (lat != 3 + p) $display("FAIL b2b_latency job=%0d got=%0d required=%0d",
                                 t, lat, 3 + p);
      else passed++;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_writes();
    test_zero();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d required=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
